peripheral_apb4_arbiter: RTL and testbench
==========================================

# peripheral_apb4_arbiter

Round-robin arbiter and APB4 master sequencer that shares one APB4 completer (such as the peripheral memory slave) among NREQ local requesters. Each requester issues single read/write commands over a valid/ready port. The block serialises them into compliant SETUP/ACCESS APB4 transfers and returns a one-cycle response pulse carrying read data and error status. It sits between the core-side request fabric and the APB4 peripheral bus.

## Interface
- NREQ, 4: number of requesters (2..8)
- TIMEOUT, 16: max ACCESS cycles with PREADY low before abort; 0 disables timeout
- PCLK  in  1  clock; all logic on rising edge
- PRESETn  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester command valid
- req_ready  out  NREQ  one-hot accept, combinational: high only in IDLE for the granted index
- req_write  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*32  packed addresses, requester i at [32*i+31:32*i]
- req_wdata  in  NREQ*32  packed write data, same packing
- rsp_valid  out  NREQ  one-cycle completion pulse to the owning requester
- rsp_rdata  out  32  read data (0 for writes and aborts), valid with rsp_valid
- rsp_err  out  1  PSLVERR or timeout, valid with rsp_valid
- PADDR, PWRITE, PWDATA  out  32/1/32  APB4 address, direction, write data
- PSTRB  out  4  4'hF on writes, 4'h0 on reads
- PPROT  out  3  constant 3'b000
- PSEL, PENABLE  out  1/1  APB4 select/enable
- PRDATA, PREADY, PSLVERR  in  32/1/1  completer response

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: if any req_valid, the grant is the first set bit scanning from (last+1) mod NREQ upward with wrap. req_ready[grant]=1. At the edge, latch addr/write/wdata, update last=grant, go to SETUP. With no req_valid, stay in IDLE.
- SETUP: PSEL=1, PENABLE=0. Go unconditionally to ACCESS; clear the wait counter.
- ACCESS: PSEL=1, PENABLE=1.
  - If PREADY=1, go to IDLE, pulse rsp_valid[grant], set rsp_rdata=PRDATA on reads or 0 on writes, and set rsp_err=PSLVERR.
  - If PREADY=0, increment the wait counter.
  - If the counter equals TIMEOUT (TIMEOUT≠0) with PREADY still 0, abort: go to IDLE, PSEL=PENABLE=0, rsp_valid[grant]=1, rsp_err=1, rsp_rdata=0.
- Requesters hold req_valid and payload stable until req_ready. The arbiter never drops or reorders an accepted command.
- PADDR/PWRITE/PWDATA/PSTRB are stable from SETUP through the end of ACCESS. They retain their last values in IDLE.
- Only one outstanding transfer exists at a time. rsp_rdata and rsp_err hold their values until the next response.

## Timing
- Reset (async assert, sync release): state IDLE, last=NREQ-1 (requester 0 highest first), PSEL=PENABLE=PWRITE=0, PADDR=PWDATA=0, PSTRB=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter 0. req_ready=0 until the first IDLE cycle with a valid.
- Zero-wait transfer: accept at edge E0, SETUP in cycle E0..E1, ACCESS in E1..E2 with PREADY sampled at E2, rsp_valid high in cycle E2..E3.
- The response cycle is an IDLE cycle, so a new grant may be issued in the same cycle as rsp_valid. Back-to-back throughput is 3 cycles per zero-wait transfer.
- Each wait state adds 1 cycle. A timeout abort occurs TIMEOUT cycles after ACCESS entry if PREADY never rises.
- A PREADY asserted in SETUP is ignored.
- A PREADY arriving on the same edge that the counter hits TIMEOUT completes normally and is not treated as an abort.
- Reset mid-transfer: the bus is deasserted immediately and no rsp_valid is issued for the in-flight command.
- A requester that deasserts req_valid before grant simply drops out of the scan.

## Test plan
- Single write: req 1 writes addr 0x10 data 0xCAFE0001, PREADY=1 in ACCESS -> PSEL 2 cycles, PENABLE 1 cycle, PSTRB=4'hF, rsp_valid[1] 3 cycles after accept, rsp_err=0.
- Read with 3 wait states: req 0 reads 0x10, completer returns 0xCAFE0001 -> ACCESS lasts 4 cycles, rsp_rdata=0xCAFE0001, PSTRB=0.
- Fairness: all 4 req_valid held high for 8 transfers -> grant order 0,1,2,3,0,1,2,3, no gaps beyond 3 cycles/transfer.
- Timeout: PREADY tied 0, TIMEOUT=16 -> abort after 16 ACCESS cycles, rsp_valid with rsp_err=1, rsp_rdata=0; next request proceeds normally.
- Error: PSLVERR=1 with PREADY on a write -> rsp_err=1 for that response only.
- Reset mid-ACCESS: PRESETn low during a wait state -> all outputs at reset values within the same cycle, no rsp_valid; after release req 0 wins first.

Source files
------------

// File: rtl/peripheral_apb4_arbiter.sv
// Round-robin arbiter that serialises single read/write commands from NREQ
// requesters onto one APB4 completer, returning a one-cycle response pulse.
module peripheral_apb4_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_write,
  input  logic [NREQ*32-1:0]   req_addr,
  input  logic [NREQ*32-1:0]   req_wdata,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic [31:0]          PADDR,
  output logic                 PWRITE,
  output logic [31:0]          PWDATA,
  output logic [3:0]           PSTRB,
  output logic [2:0]           PPROT,
  output logic                 PSEL,
  output logic                 PENABLE,
  input  logic [31:0]          PRDATA,
  input  logic                 PREADY,
  input  logic                 PSLVERR
);

  localparam int unsigned IDXW = (NREQ < 2) ? 1 : $clog2(NREQ);
  localparam int unsigned CNTW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNTW-1:0] CNT_LAST = (TIMEOUT == 0) ? CNTW'(0) : CNTW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t            state;
  logic [IDXW-1:0]   last;
  logic [CNTW-1:0]   wait_cnt;
  logic [IDXW-1:0]   grant;
  logic              grant_vld;
  logic [IDXW-1:0]   scan_idx;

  // Round-robin scan starting one past the previous owner, with wrap.
  always_comb begin
    grant     = last;
    grant_vld = 1'b0;
    scan_idx  = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      scan_idx = IDXW'((32'(last) + off) % NREQ);
      if (!grant_vld && req_valid[scan_idx]) begin
        grant     = scan_idx;
        grant_vld = 1'b1;
      end
    end
  end

  assign req_ready = (state == S_IDLE && grant_vld) ? (NREQ'(1) << grant) : '0;
  assign PPROT     = 3'b000;

  // Sequencer: IDLE -> SETUP -> ACCESS (wait/timeout) -> IDLE with response pulse.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= S_IDLE;
      last      <= IDXW'(NREQ - 1);
      wait_cnt  <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= '0;
      unique case (state)
        S_IDLE: begin
          if (grant_vld) begin
            state   <= S_SETUP;
            last    <= grant;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            PADDR   <= req_addr[32*grant +: 32];
            PWDATA  <= req_wdata[32*grant +: 32];
            PWRITE  <= req_write[grant];
            PSTRB   <= req_write[grant] ? 4'hF : 4'h0;
          end
        end
        S_SETUP: begin
          state    <= S_ACCESS;
          PENABLE  <= 1'b1;
          wait_cnt <= '0;
        end
        S_ACCESS: begin
          if (PREADY) begin
            state     <= S_IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= NREQ'(1) << last;
            rsp_rdata <= PWRITE ? 32'h0 : PRDATA;
            rsp_err   <= PSLVERR;
          end else if (TIMEOUT != 0 && wait_cnt == CNT_LAST) begin
            // Completer never answered: abandon the transfer and report an error.
            state     <= S_IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= NREQ'(1) << last;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNTW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_apb4_arbiter.sv
// Self-checking bench for peripheral_apb4_arbiter: directed vector table,
// hand-written corner sequences and a randomized run against a reference model.
module tb_peripheral_apb4_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;

  logic                PCLK;
  logic                PRESETn;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ-1:0]     req_write;
  logic [NREQ*32-1:0]  req_addr;
  logic [NREQ*32-1:0]  req_wdata;
  logic [NREQ-1:0]     rsp_valid;
  logic [31:0]         rsp_rdata;
  logic                rsp_err;
  logic [31:0]         PADDR;
  logic                PWRITE;
  logic [31:0]         PWDATA;
  logic [3:0]          PSTRB;
  logic [2:0]          PPROT;
  logic                PSEL;
  logic                PENABLE;
  logic [31:0]         PRDATA;
  logic                PREADY;
  logic                PSLVERR;

  peripheral_apb4_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
    .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] prev_rdata = 32'h0;
  logic        prev_err   = 1'b0;

  typedef struct {
    int          r;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] rdata;
    bit          slverr;
    bit          setup_rdy;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_access;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic vec_t mk(input int r, input bit wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input int waits,
                              input logic [31:0] rdata, input bit slverr, input bit setup_rdy,
                              input logic [31:0] exp_rdata, input bit exp_err,
                              input int exp_access);
    vec_t v;
    v.r = r; v.wr = wr; v.addr = addr; v.wdata = wdata; v.waits = waits;
    v.rdata = rdata; v.slverr = slverr; v.setup_rdy = setup_rdy;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_access = exp_access;
    return v;
  endfunction

  task automatic apply_reset();
    @(negedge PCLK);
    PRESETn   = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    PRDATA    = '0;
    repeat (2) @(negedge PCLK);
    PRESETn    = 1'b1;
    prev_rdata = 32'h0;
    prev_err   = 1'b0;
  endtask

  // One isolated transfer from a single requester, completer behaviour from the vector.
  task automatic do_xfer(input vec_t v);
    int cyc;
    bit done;
    @(negedge PCLK);
    chk("rsp_pulse_width", 32'(rsp_valid), 32'd0);
    chk("rsp_rdata_hold", rsp_rdata, prev_rdata);
    chk("rsp_err_hold", 32'(rsp_err), 32'(prev_err));
    req_valid               = '0;
    req_valid[v.r]          = 1'b1;
    req_write[v.r]          = v.wr;
    req_addr[32*v.r +: 32]  = v.addr;
    req_wdata[32*v.r +: 32] = v.wdata;
    PREADY                  = 1'b0;
    #1;
    chk("req_ready_grant", 32'(req_ready), 32'(oh(v.r)));
    @(negedge PCLK);
    req_valid = '0;
    chk("setup_sel_en", 32'({PSEL, PENABLE}), 32'b10);
    chk("setup_paddr", PADDR, v.addr);
    chk("setup_pwrite", 32'(PWRITE), 32'(v.wr));
    chk("setup_pwdata", PWDATA, v.wdata);
    chk("setup_pstrb", 32'(PSTRB), v.wr ? 32'hF : 32'h0);
    PREADY  = v.setup_rdy;
    PRDATA  = 32'hBAD0BAD0;
    PSLVERR = 1'b1;
    cyc  = 0;
    done = 0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge PCLK);
      if (PSEL && PENABLE) begin
        cyc++;
        if (cyc == 1) chk("access_paddr_stable", PADDR, v.addr);
        if (cyc == v.waits + 1) begin
          PREADY = 1'b1; PRDATA = v.rdata; PSLVERR = v.slverr;
        end else begin
          PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);
        end
      end else begin
        done = 1;
        chk("rsp_valid_owner", 32'(rsp_valid), 32'(oh(v.r)));
        chk("rsp_rdata", rsp_rdata, v.exp_rdata);
        chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
        chk("access_cycles", 32'(cyc), 32'(v.exp_access));
        chk("rsp_bus_idle", 32'({PSEL, PENABLE}), 32'b00);
        chk("paddr_retained", PADDR, v.addr);
        prev_rdata = v.exp_rdata;
        prev_err   = v.exp_err;
        PREADY     = 1'b0;
        PSLVERR    = 1'b0;
      end
    end
    chk("xfer_bound", 32'(done), 32'd1);
  endtask

  // Random-run reference model state.
  bit          pend[NREQ];
  bit          pwr[NREQ];
  logic [31:0] paddr_m[NREQ];
  logic [31:0] pwdata_m[NREQ];

  initial begin
    automatic int k, lastc;
    automatic int mlast, cyc, w, own, g;
    automatic bit busy, owr, oerr;
    automatic logic [31:0] oaddr, owdata, ordata;

    vecs[0] = mk(1, 1, 32'h10, 32'hCAFE0001, 0,    32'h0,        0, 0, 32'h0,        0, 1);
    vecs[1] = mk(0, 0, 32'h10, 32'h0,        3,    32'hCAFE0001, 0, 0, 32'hCAFE0001, 0, 4);
    vecs[2] = mk(2, 1, 32'h20, 32'h5555AAAA, 0,    32'hDEADBEEF, 1, 0, 32'h0,        1, 1);
    vecs[3] = mk(3, 0, 32'h30, 32'h0,        0,    32'h12345678, 0, 1, 32'h12345678, 0, 1);
    vecs[4] = mk(1, 0, 32'h44, 32'h0,        1000, 32'h0,        0, 0, 32'h0,        1, TIMEOUT);
    vecs[5] = mk(2, 0, 32'h50, 32'h0,        TIMEOUT - 1, 32'hA5A5A5A5, 0, 0, 32'hA5A5A5A5, 0, TIMEOUT);
    vecs[6] = mk(0, 0, 32'h60, 32'h0,        2,    32'h600DF00D, 0, 0, 32'h600DF00D, 0, 3);

    PRESETn = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    apply_reset();

    // Reset values.
    #1;
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_pwrite", 32'(PWRITE), 32'd0);
    chk("rst_paddr", PADDR, 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    chk("rst_pstrb", 32'(PSTRB), 32'd0);
    chk("rst_pprot", 32'(PPROT), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);

    for (int i = 0; i < 7; i++) do_xfer(vecs[i]);

    // Reset in the middle of a wait state.
    @(negedge PCLK);
    req_valid = '0; req_valid[2] = 1'b1; req_write[2] = 1'b0;
    req_addr[64 +: 32] = 32'h40; PREADY = 1'b0;
    @(negedge PCLK);
    req_valid = '0;
    repeat (3) @(negedge PCLK);
    chk("mid_in_access", 32'({PSEL, PENABLE}), 32'b11);
    PRESETn = 1'b0;
    #1;
    chk("mid_rst_psel", 32'(PSEL), 32'd0);
    chk("mid_rst_penable", 32'(PENABLE), 32'd0);
    chk("mid_rst_paddr", PADDR, 32'd0);
    chk("mid_rst_pwrite", 32'(PWRITE), 32'd0);
    chk("mid_rst_pstrb", 32'(PSTRB), 32'd0);
    chk("mid_rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge PCLK);
    chk("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = 1'b1; req_write[i] = 1'b0; req_addr[32*i +: 32] = 32'h200 + 32'(4*i);
    end
    #1;
    chk("post_rst_req0_first", 32'(req_ready), 32'b0001);
    @(negedge PCLK);
    req_valid = '0;
    chk("post_rst_paddr", PADDR, 32'h200);
    PREADY = 1'b1; PRDATA = 32'h11; PSLVERR = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("post_rst_rsp", 32'(rsp_valid), 32'b0001);
    chk("post_rst_rdata", rsp_rdata, 32'h11);
    PREADY = 1'b0;

    // Fairness with every requester permanently valid.
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = 1'b1; req_write[i] = 1'b1;
      req_addr[32*i +: 32] = 32'h100 + 32'(4*i); req_wdata[32*i +: 32] = 32'(i);
    end
    PREADY = 1'b1;
    k = 0; lastc = 0;
    for (int n = 0; n < 60 && k < 8; n++) begin
      @(negedge PCLK);
      if (PSEL && !PENABLE) begin
        chk("rr_order", (PADDR - 32'h100) >> 2, 32'(k % NREQ));
        if (k > 0) chk("rr_spacing", 32'(n - lastc), 32'd3);
        lastc = n;
        k++;
      end
    end
    req_valid = '0;
    chk("rr_count", 32'(k), 32'd8);
    repeat (4) @(negedge PCLK);
    PREADY = 1'b0;

    // Randomized traffic against the reference model.
    apply_reset();
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
    mlast = NREQ - 1; busy = 0; cyc = 0; w = 0; own = 0;
    owr = 0; oerr = 0; oaddr = '0; owdata = '0; ordata = '0;
    for (int t = 0; t < 400; t++) begin
      @(negedge PCLK);
      if (busy) begin
        cyc++;
        if (cyc == 1) begin
          chk("rnd_setup", 32'({PSEL, PENABLE}), 32'b10);
          chk("rnd_paddr", PADDR, oaddr);
          chk("rnd_pwrite", 32'(PWRITE), 32'(owr));
          chk("rnd_pwdata", PWDATA, owdata);
          chk("rnd_pstrb", 32'(PSTRB), owr ? 32'hF : 32'h0);
          PREADY = 1'($urandom);
        end else if (cyc <= w + 2) begin
          chk("rnd_access", 32'({PSEL, PENABLE}), 32'b11);
          if (cyc - 1 == w + 1) begin
            PREADY = 1'b1; PRDATA = ordata; PSLVERR = oerr;
          end else begin
            PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);
          end
        end else begin
          chk("rnd_rsp_valid", 32'(rsp_valid), 32'(oh(own)));
          chk("rnd_rsp_rdata", rsp_rdata, owr ? 32'h0 : ordata);
          chk("rnd_rsp_err", 32'(rsp_err), 32'(oerr));
          busy   = 0;
          PREADY = 1'b0;
        end
      end else begin
        chk("rnd_no_rsp", 32'(rsp_valid), 32'd0);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i]) begin
          if (t < 360 && $urandom_range(99) < 30) begin
            pend[i] = 1; pwr[i] = 1'($urandom); paddr_m[i] = $urandom; pwdata_m[i] = $urandom;
          end
        end else if ($urandom_range(99) < 5) begin
          pend[i] = 0;
        end
        req_valid[i]            = pend[i];
        req_write[i]            = pwr[i];
        req_addr[32*i +: 32]    = paddr_m[i];
        req_wdata[32*i +: 32]   = pwdata_m[i];
      end
      #1;
      if (!busy) begin
        g = -1;
        for (int off = 1; off <= NREQ; off++)
          if (g < 0 && pend[(mlast + off) % NREQ]) g = (mlast + off) % NREQ;
        chk("rnd_req_ready", 32'(req_ready), g < 0 ? 32'd0 : 32'(oh(g)));
        if (g >= 0) begin
          busy = 1; cyc = 0; own = g; owr = pwr[g];
          oaddr = paddr_m[g]; owdata = pwdata_m[g];
          w = $urandom_range(3); ordata = $urandom; oerr = ($urandom_range(3) == 0);
          mlast = g; pend[g] = 0;
        end
      end else begin
        chk("rnd_ready_busy", 32'(req_ready), 32'd0);
      end
    end
    chk("rnd_drained", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

endmodule
